// File: rtl/fp_std_0.sv
// Operand front stage of the 24-bit FP add/sub/max/min datapath.
// Two-stage elastic pipeline. S1 unpacks, compares and swaps the operands.
// S2 aligns the smaller one, forms the raw add/sub mantissas and picks max/min.
// Ports: clk_i, rst_ni, valid_i/ready_o, a_i, b_i, op_i in;
// valid_o/ready_i, op_o, add/sub mantissas, max/min signs, max exponent,
// max_result_o and min_result_o out.
module fp_std_0 #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [3:0]       op_o,
  output logic [16:0]      add_result_mantissa_o,
  output logic [15:0]      sub_result_mantissa_o,
  output logic             max_sign_o,
  output logic             min_sign_o,
  output logic [7:0]       max_exponent_o,
  output logic [WIDTH-1:0] max_result_o,
  output logic [WIDTH-1:0] min_result_o
);

  localparam int FW = WIDTH - 9;
  localparam int MW = FW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             sl;
    logic             ss;
    logic [7:0]       el;
    logic [7:0]       diff;
    logic [MW-1:0]    ml;
    logic [MW-1:0]    ms;
  } s1_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [16:0]      add;
    logic [15:0]      sub;
    logic             smax;
    logic             smin;
    logic [7:0]       emax;
    logic [WIDTH-1:0] maxr;
    logic [WIDTH-1:0] minr;
  } s2_t;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_valid, s2_valid;
  logic s2_load;

  assign s2_load = !s2_valid || ready_i;
  assign ready_o = !s1_valid || s2_load;
  assign valid_o = s2_valid;

  // S1: unpack, flush zero-exponent operands, magnitude compare/swap
  logic [7:0]    ea, eb;
  logic [MW-1:0] ma, mb;
  logic          neg_b, sa, sb, a_big;

  always_comb begin
    ea    = a_i[WIDTH-2:WIDTH-9];
    eb    = b_i[WIDTH-2:WIDTH-9];
    ma    = (ea == 8'd0) ? '0 : {1'b1, a_i[FW-1:0]};
    mb    = (eb == 8'd0) ? '0 : {1'b1, b_i[FW-1:0]};
    neg_b = op_i[2] && (op_i[1:0] == 2'b00);
    sa    = a_i[WIDTH-1];
    sb    = b_i[WIDTH-1] ^ neg_b;
    // ties keep A as the larger operand
    a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
    s1_d      = '0;
    s1_d.a    = a_i;
    s1_d.b    = b_i;
    s1_d.op   = op_i;
    s1_d.sl   = a_big ? sa : sb;
    s1_d.ss   = a_big ? sb : sa;
    s1_d.el   = a_big ? ea : eb;
    s1_d.diff = a_big ? (ea - eb) : (eb - ea);
    s1_d.ml   = a_big ? ma : mb;
    s1_d.ms   = a_big ? mb : ma;
  end

  // S2: align, raw arithmetic, signed max/min on the unnegated operands
  logic [MW-1:0]    al;
  logic             ra, rb;
  logic [WIDTH-2:0] xa, xb;
  logic             a_gt, b_gt;

  always_comb begin
    al = (s1_q.diff >= 8'd16) ? '0 : (s1_q.ms >> s1_q.diff[3:0]);
    ra = s1_q.a[WIDTH-1];
    rb = s1_q.b[WIDTH-1];
    xa = s1_q.a[WIDTH-2:0];
    xb = s1_q.b[WIDTH-2:0];
    // sign-magnitude order: -0 sorts below +0
    if (ra != rb) begin
      a_gt = !ra;
      b_gt = !rb;
    end else if (!ra) begin
      a_gt = xa > xb;
      b_gt = xb > xa;
    end else begin
      a_gt = xa < xb;
      b_gt = xb < xa;
    end
    s2_d      = '0;
    s2_d.op   = s1_q.op;
    s2_d.add  = {1'b0, s1_q.ml} + {1'b0, al};
    s2_d.sub  = s1_q.ml - al;
    s2_d.smax = s1_q.sl;
    s2_d.smin = s1_q.ss;
    s2_d.emax = s1_q.el;
    s2_d.maxr = b_gt ? s1_q.b : s1_q.a;
    s2_d.minr = a_gt ? s1_q.b : s1_q.a;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
      if (valid_i) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  assign op_o                  = s2_q.op;
  assign add_result_mantissa_o = s2_q.add;
  assign sub_result_mantissa_o = s2_q.sub;
  assign max_sign_o            = s2_q.smax;
  assign min_sign_o            = s2_q.smin;
  assign max_exponent_o        = s2_q.emax;
  assign max_result_o          = s2_q.maxr;
  assign min_result_o          = s2_q.minr;

endmodule

// File: tb/tb_fp_std_0.sv
// Directed-vector bench for the fp_std_0 operand stage.
// One task per scenario, each checking its own expected values.
module tb_fp_std_0;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [23:0] a_i = '0;
  logic [23:0] b_i = '0;
  logic [3:0]  op_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [3:0]  op_o;
  logic [16:0] add_result_mantissa_o;
  logic [15:0] sub_result_mantissa_o;
  logic        max_sign_o;
  logic        min_sign_o;
  logic [7:0]  max_exponent_o;
  logic [23:0] max_result_o;
  logic [23:0] min_result_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  fp_std_0 #(.WIDTH(24)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .a_i(a_i),
    .b_i(b_i),
    .op_i(op_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .op_o(op_o),
    .add_result_mantissa_o(add_result_mantissa_o),
    .sub_result_mantissa_o(sub_result_mantissa_o),
    .max_sign_o(max_sign_o),
    .min_sign_o(min_sign_o),
    .max_exponent_o(max_exponent_o),
    .max_result_o(max_result_o),
    .min_result_o(min_result_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // present one beat to an idle pipeline; lat counts edges until valid_o
  task automatic drive_one(input logic [23:0] a, input logic [23:0] b,
                           input logic [3:0] op, output int lat);
    a_i = a;
    b_i = b;
    op_i = op;
    ready_i = 1'b1;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_ni = 1'b0;
    ready_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    a_i = 24'h3F8000;
    b_i = 24'h3F8000;
    op_i = 4'h0;
    valid_i = 1'b1;
    tick();
    tick();
    valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      $display("FAIL rst_valid: got %b want 0", valid_o);
      errors++;
    end
    repeat (3) tick();
    checks++;
    if (add_result_mantissa_o !== 17'h0 || op_o !== 4'h0) begin
      $display("FAIL rst_data: add=%h op=%h want 0", add_result_mantissa_o, op_o);
      errors++;
    end
    checks++;
    if (max_result_o !== 24'h0 || max_exponent_o !== 8'h0) begin
      $display("FAIL rst_max: max=%h exp=%h want 0", max_result_o, max_exponent_o);
      errors++;
    end
    rst_ni = 1'b1;
    ready_i = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b1) begin
      $display("FAIL rst_ready: got %b want 1", ready_o);
      errors++;
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_o) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      $display("FAIL rst_flush: %0d stale beats want 0", seen);
      errors++;
    end
  endtask

  task automatic test_add();
    int lat;
    drive_one(24'h3F8000, 24'h3F8000, 4'h0, lat);
    checks++;
    if (lat != 2) begin
      $display("FAIL add_latency: got %0d want 2", lat);
      errors++;
    end
    checks++;
    if (add_result_mantissa_o !== 17'h10000) begin
      $display("FAIL add_mant: got %h want 10000", add_result_mantissa_o);
      errors++;
    end
    checks++;
    if (max_exponent_o !== 8'h7F || max_sign_o !== 1'b0 || min_sign_o !== 1'b0) begin
      $display("FAIL add_exp_sign: exp=%h s=%b%b want 7f 00",
               max_exponent_o, max_sign_o, min_sign_o);
      errors++;
    end
    checks++;
    if (sub_result_mantissa_o !== 16'h0) begin
      $display("FAIL add_sub: got %h want 0", sub_result_mantissa_o);
      errors++;
    end
  endtask

  task automatic test_sub();
    int lat;
    drive_one(24'h3FC000, 24'h3F8000, 4'h4, lat);
    checks++;
    if (sub_result_mantissa_o !== 16'h4000 || add_result_mantissa_o !== 17'h14000) begin
      $display("FAIL sub_mant: sub=%h add=%h want 4000 14000",
               sub_result_mantissa_o, add_result_mantissa_o);
      errors++;
    end
    checks++;
    if (max_sign_o !== 1'b0 || min_sign_o !== 1'b1 || max_exponent_o !== 8'h7F) begin
      $display("FAIL sub_sign: s=%b%b exp=%h want 01 7f",
               max_sign_o, min_sign_o, max_exponent_o);
      errors++;
    end
    checks++;
    if (op_o !== 4'h4) begin
      $display("FAIL sub_op: got %h want 4", op_o);
      errors++;
    end
  endtask

  task automatic test_large_shift();
    int lat;
    drive_one(24'h498000, 24'h3F8000, 4'h0, lat);
    checks++;
    if (add_result_mantissa_o !== 17'h08000 || sub_result_mantissa_o !== 16'h8000) begin
      $display("FAIL shift_mant: add=%h sub=%h want 08000 8000",
               add_result_mantissa_o, sub_result_mantissa_o);
      errors++;
    end
    checks++;
    if (max_exponent_o !== 8'h93) begin
      $display("FAIL shift_exp: got %h want 93", max_exponent_o);
      errors++;
    end
  endtask

  task automatic test_swap();
    int lat;
    // B larger: +1.0 + +2.0, aligned 1.0 becomes 0x4000
    drive_one(24'h3F8000, 24'h400000, 4'h0, lat);
    checks++;
    if (max_exponent_o !== 8'h80 || add_result_mantissa_o !== 17'h0C000) begin
      $display("FAIL swap: exp=%h add=%h want 80 0c000",
               max_exponent_o, add_result_mantissa_o);
      errors++;
    end
    // zero exponent flushes A, B is larger with diff 0x7f
    drive_one(24'h001234, 24'hBF8000, 4'h0, lat);
    checks++;
    if (add_result_mantissa_o !== 17'h08000 || max_sign_o !== 1'b1 ||
        min_sign_o !== 1'b0) begin
      $display("FAIL flush: add=%h s=%b%b want 08000 10",
               add_result_mantissa_o, max_sign_o, min_sign_o);
      errors++;
    end
  endtask

  task automatic test_max_min();
    int lat;
    drive_one(24'h3F8000, 24'hC00000, 4'h1, lat);
    checks++;
    if (max_result_o !== 24'h3F8000 || min_result_o !== 24'hC00000) begin
      $display("FAIL maxmin_mixed: max=%h min=%h want 3f8000 c00000",
               max_result_o, min_result_o);
      errors++;
    end
    drive_one(24'h000000, 24'h800000, 4'h2, lat);
    checks++;
    if (max_result_o !== 24'h000000 || min_result_o !== 24'h800000) begin
      $display("FAIL maxmin_zero: max=%h min=%h want 000000 800000",
               max_result_o, min_result_o);
      errors++;
    end
    drive_one(24'hC00000, 24'hBF8000, 4'h1, lat);
    checks++;
    if (max_result_o !== 24'hBF8000 || min_result_o !== 24'hC00000) begin
      $display("FAIL maxmin_neg: max=%h min=%h want bf8000 c00000",
               max_result_o, min_result_o);
      errors++;
    end
  endtask

  logic [3:0]  got_op[4];
  logic [16:0] got_add[4];

  task automatic test_back_to_back();
    int n_got, acc_at_stall, acc, extra;
    logic stalled;
    n_got = 0;
    acc = 0;
    acc_at_stall = -1;
    stalled = 1'b0;
    extra = 0;
    ready_i = 1'b0;
    fork
      begin
        for (int t = 0; t < 40 && n_got < 4; t++) begin
          ready_i = (t >= 3);
          if (valid_o && ready_i) begin
            got_op[n_got] = op_o;
            got_add[n_got] = add_result_mantissa_o;
            n_got++;
          end
          tick();
        end
        ready_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
          if (valid_o) extra++;
          tick();
        end
      end
      begin
        #1;
        for (int i = 0; i < 4; i++) begin
          a_i = 24'h3F8000 + 24'(i * 24'h1000);
          b_i = 24'h3F8000;
          op_i = {2'b10, 2'(i)};
          valid_i = 1'b1;
          for (int w = 0; w < 20; w++) begin
            logic rdy;
            rdy = ready_o;
            if (!rdy && !stalled) begin
              stalled = 1'b1;
              acc_at_stall = acc;
            end
            @(posedge clk_i);
            #2;
            if (rdy) break;
          end
          acc++;
        end
        valid_i = 1'b0;
      end
    join
    checks++;
    if (acc_at_stall != 2) begin
      $display("FAIL bp_stall: ready fell after %0d beats want 2", acc_at_stall);
      errors++;
    end
    checks++;
    if (n_got != 4 || extra != 0) begin
      $display("FAIL bp_count: got %0d extra %0d want 4 0", n_got, extra);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_op[i] !== {2'b10, 2'(i)} ||
          got_add[i] !== 17'h10000 + 17'(i * 17'h1000)) begin
        $display("FAIL bp_beat%0d: op=%h add=%h want %h %h", i, got_op[i],
                 got_add[i], {2'b10, 2'(i)}, 17'h10000 + 17'(i * 17'h1000));
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_large_shift();
    test_swap();
    test_max_min();
    tick();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
